// File: rtl/pmod_pkg.sv
// Shared types and constants for the PMOD serial receive / BCD conversion path.
package pmod_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStart   = 3'd1,
      StData    = 3'd2,
      StStop    = 3'd3,
      StConvert = 3'd4,
      StDone    = 3'd5,
      StParity  = 3'd6
   } state_e;

   // 25 MHz / 115200 baud
   localparam int unsigned ClksPerBitDefault = 217;
   localparam int unsigned BcdW              = 4;
   localparam int unsigned BcdScratchW       = 3 * BcdW;

   function automatic logic [BcdW-1:0] dabble_adj(input logic [BcdW-1:0] digit);
      return (digit >= BcdW'(5)) ? digit + BcdW'(3) : digit;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one iteration per clock, DATA_BITS iterations after a start strobe.
module bin2bcd_seq
   import pmod_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] bin,
   output logic [BcdW-1:0]      hund,
   output logic [BcdW-1:0]      tens,
   output logic [BcdW-1:0]      ones,
   output logic                 done
);

   localparam int unsigned IterW = $clog2(DATA_BITS);
   localparam logic [IterW-1:0] IterLast = IterW'(DATA_BITS - 1);

   logic [DATA_BITS-1:0]   bin_q, bin_d;
   logic [BcdScratchW-1:0] bcd_q, bcd_d;
   logic [BcdScratchW-1:0] bcd_adj;
   logic [IterW-1:0]       iter_q, iter_d;
   logic                   busy_q, busy_d;

   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      bcd_adj = {dabble_adj(bcd_q[3*BcdW-1:2*BcdW]),
                 dabble_adj(bcd_q[2*BcdW-1:BcdW]),
                 dabble_adj(bcd_q[BcdW-1:0])};
      // Asserted during the final iteration; digits are settled the following cycle.
      done    = busy_q && (iter_q == IterLast);

      if (start) begin
         bin_d  = bin;
         bcd_d  = '0;
         iter_d = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d  = {bcd_adj[BcdScratchW-2:0], bin_q[DATA_BITS-1]};
         bin_d  = {bin_q[DATA_BITS-2:0], 1'b0};
         iter_d = iter_q + IterW'(1);
         if (done) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         iter_q <= iter_d;
         busy_q <= busy_d;
      end
   end

   assign hund = bcd_q[3*BcdW-1:2*BcdW];
   assign tens = bcd_q[2*BcdW-1:BcdW];
   assign ones = bcd_q[BcdW-1:0];

endmodule

// File: rtl/pmod_rx_bcd_ctrl.sv
// Framed serial receiver for io_PMOD_1 feeding a sequential binary-to-BCD converter.
// Optional parity stage enabled by defining PMOD_RX_PARITY_EN.
module pmod_rx_bcd_ctrl
   import pmod_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic                 i_Rx,
   output logic [DATA_BITS-1:0] o_Byte,
   output logic [BcdW-1:0]      o_Bcd_Hund,
   output logic [BcdW-1:0]      o_Bcd_Tens,
   output logic [BcdW-1:0]      o_Bcd_Ones,
   output logic                 o_Valid,
   output logic                 o_Frame_Err,
   output logic                 o_Busy
);

   localparam int unsigned ClkCntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitCntW = $clog2(DATA_BITS);
   localparam logic [ClkCntW-1:0] HalfLast = ClkCntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ClkCntW-1:0] BitLast  = ClkCntW'(CLKS_PER_BIT - 1);
   localparam logic [BitCntW-1:0] DataLast = BitCntW'(DATA_BITS - 1);

   logic                 rx_meta, rx_s;
   state_e               state_q, state_d;
   logic [ClkCntW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic [BcdW-1:0]      hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 conv_start, conv_done;
   logic [BcdW-1:0]      conv_hund, conv_tens, conv_ones;

   // Preset high so reset looks like an idle line rather than a start bit.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_Rx;
         rx_s    <= rx_meta;
      end
   end

   bin2bcd_seq #(
      .DATA_BITS (DATA_BITS)
   ) u_bin2bcd (
      .clk   (i_Clk),
      .rst_n (i_Rst_n),
      .start (conv_start),
      .bin   (shift_q),
      .hund  (conv_hund),
      .tens  (conv_tens),
      .ones  (conv_ones),
      .done  (conv_done)
   );

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      conv_start = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d   = StStart;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end

         StStart: begin
            if (clk_cnt_q == HalfLast) begin
               clk_cnt_d = '0;
               state_d   = rx_s ? StIdle : StData;
            end else begin
               clk_cnt_d = clk_cnt_q + ClkCntW'(1);
            end
         end

         StData: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = '0;
               // Shifting in from the top leaves bit k at index k after all samples.
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BitCntW'(1);
               if (bit_cnt_q == DataLast) begin
`ifdef PMOD_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ClkCntW'(1);
            end
         end

`ifdef PMOD_RX_PARITY_EN
         StParity: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = '0;
               if (^{shift_q, rx_s}) begin
                  ferr_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StStop;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ClkCntW'(1);
            end
         end
`endif

         StStop: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = '0;
               if (rx_s) begin
                  conv_start = 1'b1;
                  state_d    = StConvert;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StIdle;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ClkCntW'(1);
            end
         end

         StConvert: begin
            if (conv_done) begin
               state_d = StDone;
            end
         end

         StDone: begin
            byte_d  = shift_q;
            hund_d  = conv_hund;
            tens_d  = conv_tens;
            ones_d  = conv_ones;
            valid_d = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= StIdle;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         hund_q    <= '0;
         tens_q    <= '0;
         ones_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         hund_q    <= hund_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign o_Byte      = byte_q;
   assign o_Bcd_Hund  = hund_q;
   assign o_Bcd_Tens  = tens_q;
   assign o_Bcd_Ones  = ones_q;
   assign o_Valid     = valid_q;
   assign o_Frame_Err = ferr_q;
   assign o_Busy      = (state_q != StIdle);

endmodule
